calc_entry_ctrl: RTL
====================

Name: calc_entry_ctrl

Overview:
- Sequencer for the keypad calculator datapath. Takes the raw 8-bit keypad row/column code and debounces it into single key events.
- Steps the user through operand X, operator, operand Y and execute, then drives the ALU through a start/done handshake.
- Captures the ALU result for display. Sits between the keypad pins and the ALU/seven-segment display path.

Parameters:
- W, 16, operand/result width in bits
- MAX_DIGITS, 4, maximum decimal digits accepted per operand
- DEB_CYC, 500000, cycles a code must be stable before it counts as a press or release
- ALU_TMO, 1024, cycles to wait for alu_done before flagging an error

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- keypad  in  8  raw code: [7:4] row one-hot, [3:0] column one-hot, 8'h00 = no key
- alu_done  in  1  ALU result valid, single-cycle pulse
- alu_result  in  W  ALU result, sampled when alu_done=1
- op_x  out  W  operand X, binary
- op_y  out  W  operand Y, binary
- alu_op  out  6  operation code
- alu_start  out  1  single-cycle execute pulse
- result  out  W  last captured ALU result
- disp_val  out  W  value to display: op_x, op_y or result, depending on state
- state_o  out  3  current FSM state encoding
- err  out  1  sticky ALU timeout flag

Behaviour:
- Key codes:
  - Digits: 0=8'h14, 1=8'h88, 2=8'h84, 3=8'h82, 4=8'h48, 5=8'h44, 6=8'h42, 7=8'h28, 8=8'h24, 9=8'h22.
  - Operators: A=8'h81, B=8'h41, C=8'h21, D=8'h11.
  - Control: STAR=8'h18, HASH=8'h12.
  - Any other nonzero code is invalid and is ignored after debounce.
- Debounce:
  - keypad is registered twice for synchronisation.
  - A counter restarts whenever the synchronised code changes.
  - When the code has been stable for DEB_CYC cycles and is nonzero while the unit is armed, exactly one key event pulse is produced and the unit disarms.
  - The unit re-arms only after 8'h00 has been stable for DEB_CYC cycles. A held key therefore produces exactly one event.
  - A code change while disarmed does not produce an event.
- Opcodes: A=6'b000010 (add), B=6'b010011 (sub), C=6'b010101 (or), D=6'b000000 (and).
- Digit accumulation:
  - operand <= operand*10 + digit, computed in W+4 bits and truncated to W bits.
  - A per-operand digit counter tracks entered digits. Digits beyond MAX_DIGITS are ignored.
- FSM states:
  - ENTER_X (reset state):
    - digit: accumulate into op_x.
    - STAR: clear op_x and its digit count.
    - HASH: go to WAIT_OP.
  - WAIT_OP:
    - A-D: latch alu_op, go to WAIT_STAR.
    - HASH: back to ENTER_X, op_x kept.
    - Others ignored.
  - WAIT_STAR:
    - STAR: clear op_y, go to ENTER_Y.
    - A-D: replace alu_op.
    - Others ignored.
  - ENTER_Y:
    - digit: accumulate into op_y.
    - STAR: clear op_y.
    - HASH with at least one Y digit: go to EXEC.
    - HASH with zero Y digits: ignored.
  - EXEC:
    - alu_start=1 for exactly this one cycle, then go to WAIT_DONE.
  - WAIT_DONE:
    - alu_done: result<=alu_result, go to SHOW.
    - Timeout counter reaches ALU_TMO: err<=1, go to SHOW, result unchanged.
    - All key events are ignored.
  - SHOW:
    - digit: clear op_x, op_y and both digit counts, load op_x<=digit, go to ENTER_X.
    - STAR: clear op_x and op_y, go to ENTER_X.
    - HASH: op_x<=result, digit count=MAX_DIGITS (chaining), go to WAIT_OP.
- alu_done outside WAIT_DONE is ignored.
- op_x, op_y and alu_op are held stable from EXEC through SHOW.
- disp_val:
  - op_x in ENTER_X and WAIT_OP.
  - op_y in WAIT_STAR and ENTER_Y.
  - result in EXEC, WAIT_DONE and SHOW.
  - Combinational from registers.
- err clears only on reset or on a STAR event in SHOW.
- Reset (asynchronous, at any time including mid-debounce or in WAIT_DONE):
  - state=ENTER_X, disarmed.
  - op_x, op_y, result, alu_op, counters = 0; alu_start=0, err=0.
  - The unit re-arms only after idle is stable.

Decomposition:
- Shared package calc_pkg: key code constants, opcode constants, state enum encoding (3 bits), and a key_class type (DIGIT/OPER/STAR/HASH/NONE).
- One sub-module, key_debounce (parameter DEB_CYC). Outputs: key_evt pulse and key_code[7:0].
- Code classification and the FSM live in calc_entry_ctrl.

Test Plan (DEB_CYC=4, ALU_TMO=16):
- Press 1, 2, 3, then HASH, A, STAR, 4, 5, HASH, each held 10 cycles with idle gaps -> op_x=123, alu_op=000010, op_y=45, one alu_start pulse. Then alu_done with alu_result=168 -> result=168, disp_val=168, state SHOW.
- Hold key 7 for 200 cycles, with 2-cycle glitches to 8'h00 inside the hold -> exactly one digit accepted, op_x=7.
- Enter 5 digits 9,9,9,9,9 -> op_x=9999. Press HASH in ENTER_Y with no digits -> no alu_start.
- In WAIT_DONE, never assert alu_done -> err=1 after 16 cycles, state SHOW, result unchanged. Press STAR -> err=0, state ENTER_X.
- In SHOW with result=20, press HASH, B, STAR, 5, HASH -> op_x=20, alu_op=010011, op_y=5, alu_start pulse.
- Assert rst_n=0 during WAIT_DONE and during a debounce count -> all outputs 0, state ENTER_X, no spurious event after release while a key is still held.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: key codes, opcodes,
// FSM state encoding and the key classification helper.
package calc_pkg;

    localparam logic [7:0] KEY_0    = 8'h14;
    localparam logic [7:0] KEY_1    = 8'h88;
    localparam logic [7:0] KEY_2    = 8'h84;
    localparam logic [7:0] KEY_3    = 8'h82;
    localparam logic [7:0] KEY_4    = 8'h48;
    localparam logic [7:0] KEY_5    = 8'h44;
    localparam logic [7:0] KEY_6    = 8'h42;
    localparam logic [7:0] KEY_7    = 8'h28;
    localparam logic [7:0] KEY_8    = 8'h24;
    localparam logic [7:0] KEY_9    = 8'h22;
    localparam logic [7:0] KEY_A    = 8'h81;
    localparam logic [7:0] KEY_B    = 8'h41;
    localparam logic [7:0] KEY_C    = 8'h21;
    localparam logic [7:0] KEY_D    = 8'h11;
    localparam logic [7:0] KEY_STAR = 8'h18;
    localparam logic [7:0] KEY_HASH = 8'h12;

    localparam logic [5:0] OP_ADD = 6'b000010;
    localparam logic [5:0] OP_SUB = 6'b010011;
    localparam logic [5:0] OP_OR  = 6'b010101;
    localparam logic [5:0] OP_AND = 6'b000000;

    typedef enum logic [2:0] {
        ST_ENTER_X   = 3'd0,
        ST_WAIT_OP   = 3'd1,
        ST_WAIT_STAR = 3'd2,
        ST_ENTER_Y   = 3'd3,
        ST_EXEC      = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_SHOW      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        KC_NONE  = 3'd0,
        KC_DIGIT = 3'd1,
        KC_OPER  = 3'd2,
        KC_STAR  = 3'd3,
        KC_HASH  = 3'd4
    } key_class_t;

    typedef struct packed {
        key_class_t  cls;
        logic [3:0]  digit;
        logic [5:0]  opcode;
    } key_dec_t;

    function automatic key_dec_t decode_key(input logic [7:0] code);
        key_dec_t d;
        d.cls    = KC_NONE;
        d.digit  = 4'd0;
        d.opcode = 6'd0;
        case (code)
            KEY_0:    begin d.cls = KC_DIGIT; d.digit = 4'd0; end
            KEY_1:    begin d.cls = KC_DIGIT; d.digit = 4'd1; end
            KEY_2:    begin d.cls = KC_DIGIT; d.digit = 4'd2; end
            KEY_3:    begin d.cls = KC_DIGIT; d.digit = 4'd3; end
            KEY_4:    begin d.cls = KC_DIGIT; d.digit = 4'd4; end
            KEY_5:    begin d.cls = KC_DIGIT; d.digit = 4'd5; end
            KEY_6:    begin d.cls = KC_DIGIT; d.digit = 4'd6; end
            KEY_7:    begin d.cls = KC_DIGIT; d.digit = 4'd7; end
            KEY_8:    begin d.cls = KC_DIGIT; d.digit = 4'd8; end
            KEY_9:    begin d.cls = KC_DIGIT; d.digit = 4'd9; end
            KEY_A:    begin d.cls = KC_OPER;  d.opcode = OP_ADD; end
            KEY_B:    begin d.cls = KC_OPER;  d.opcode = OP_SUB; end
            KEY_C:    begin d.cls = KC_OPER;  d.opcode = OP_OR;  end
            KEY_D:    begin d.cls = KC_OPER;  d.opcode = OP_AND; end
            KEY_STAR: d.cls = KC_STAR;
            KEY_HASH: d.cls = KC_HASH;
            default:  d.cls = KC_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad synchroniser and debouncer: one event per stable press, re-armed
// only after the idle code has itself been stable for DEB_CYC cycles.
module key_debounce #(
    parameter int DEB_CYC = 500000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_keypad,
    output logic       o_key_evt,
    output logic [7:0] o_key_code
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEB_CYC - 1);

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_code;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_armed;
    logic             r_evt;

    // r_code resets to a sentinel so the first synchronised value always
    // restarts the count; a key held through reset therefore never fires.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
            r_code  <= 8'hFF;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_armed <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_sync1 <= i_keypad;
            r_sync2 <= r_sync1;
            r_evt   <= 1'b0;
            if (r_sync2 != r_code) begin
                r_code <= r_sync2;
                r_cnt  <= RELOAD;
                r_done <= 1'b0;
            end else if (!r_done) begin
                if (r_cnt == '0) begin
                    r_done <= 1'b1;
                    if (r_code == 8'h00) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_evt   <= 1'b1;
                        r_armed <= 1'b0;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign o_key_evt  = r_evt;
    assign o_key_code = r_code;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad calculator entry sequencer: operand/operator entry, ALU handshake
// with timeout, and result capture for display.
//   state     | meaning
//   ENTER_X   | accumulating operand X digits
//   WAIT_OP   | waiting for operator A-D
//   WAIT_STAR | operator chosen, STAR starts operand Y
//   ENTER_Y   | accumulating operand Y digits
//   EXEC      | one-cycle alu_start
//   WAIT_DONE | waiting for alu_done or timeout
//   SHOW      | displaying result
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4,
    parameter int DEB_CYC    = 500000,
    parameter int ALU_TMO    = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   keypad,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    output logic [W-1:0] op_x,
    output logic [W-1:0] op_y,
    output logic [5:0]   alu_op,
    output logic         alu_start,
    output logic [W-1:0] result,
    output logic [W-1:0] disp_val,
    output logic [2:0]   state_o,
    output logic         err
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(ALU_TMO + 1);
    localparam logic [CW-1:0] MAXC       = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] TMO_RELOAD = TW'(ALU_TMO - 1);

    function automatic logic [W-1:0] acc_digit(input logic [W-1:0] v, input logic [3:0] d);
        logic [W+3:0] t;
        t = (W+4)'(v) * (W+4)'(10) + (W+4)'(d);
        return t[W-1:0];
    endfunction

    logic         w_key_evt;
    logic [7:0]   w_key_code;
    key_dec_t     w_dec;
    key_class_t   w_cls;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_op_x, w_op_x_nxt;
    logic [W-1:0]  r_op_y, w_op_y_nxt;
    logic [CW-1:0] r_x_cnt, w_x_cnt_nxt;
    logic [CW-1:0] r_y_cnt, w_y_cnt_nxt;
    logic [5:0]    r_alu_op, w_alu_op_nxt;
    logic [W-1:0]  r_result, w_result_nxt;
    logic          r_err, w_err_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic          w_start;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_keypad   (keypad),
        .o_key_evt  (w_key_evt),
        .o_key_code (w_key_code)
    );

    assign w_dec = decode_key(w_key_code);
    assign w_cls = w_key_evt ? w_dec.cls : KC_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ENTER_X;
            r_op_x   <= '0;
            r_op_y   <= '0;
            r_x_cnt  <= '0;
            r_y_cnt  <= '0;
            r_alu_op <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op_x   <= w_op_x_nxt;
            r_op_y   <= w_op_y_nxt;
            r_x_cnt  <= w_x_cnt_nxt;
            r_y_cnt  <= w_y_cnt_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_op_x_nxt   = r_op_x;
        w_op_y_nxt   = r_op_y;
        w_x_cnt_nxt  = r_x_cnt;
        w_y_cnt_nxt  = r_y_cnt;
        w_alu_op_nxt = r_alu_op;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        w_tmo_nxt    = r_tmo;
        w_start      = 1'b0;
        case (r_state)
            ST_ENTER_X: begin
                if (w_cls == KC_DIGIT) begin
                    if (r_x_cnt < MAXC) begin
                        w_op_x_nxt  = acc_digit(r_op_x, w_dec.digit);
                        w_x_cnt_nxt = r_x_cnt + CW'(1);
                    end
                end else if (w_cls == KC_STAR) begin
                    w_op_x_nxt  = '0;
                    w_x_cnt_nxt = '0;
                end else if (w_cls == KC_HASH) begin
                    w_state_nxt = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (w_cls == KC_OPER) begin
                    w_alu_op_nxt = w_dec.opcode;
                    w_state_nxt  = ST_WAIT_STAR;
                end else if (w_cls == KC_HASH) begin
                    w_state_nxt = ST_ENTER_X;
                end
            end
            ST_WAIT_STAR: begin
                if (w_cls == KC_STAR) begin
                    w_op_y_nxt  = '0;
                    w_y_cnt_nxt = '0;
                    w_state_nxt = ST_ENTER_Y;
                end else if (w_cls == KC_OPER) begin
                    w_alu_op_nxt = w_dec.opcode;
                end
            end
            ST_ENTER_Y: begin
                if (w_cls == KC_DIGIT) begin
                    if (r_y_cnt < MAXC) begin
                        w_op_y_nxt  = acc_digit(r_op_y, w_dec.digit);
                        w_y_cnt_nxt = r_y_cnt + CW'(1);
                    end
                end else if (w_cls == KC_STAR) begin
                    w_op_y_nxt  = '0;
                    w_y_cnt_nxt = '0;
                end else if (w_cls == KC_HASH && r_y_cnt != '0) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_start     = 1'b1;
                w_tmo_nxt   = TMO_RELOAD;
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A result arriving on the final timeout cycle still wins.
                if (alu_done) begin
                    w_result_nxt = alu_result;
                    w_state_nxt  = ST_SHOW;
                end else if (r_tmo == '0) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_SHOW;
                end else begin
                    w_tmo_nxt = r_tmo - TW'(1);
                end
            end
            ST_SHOW: begin
                if (w_cls == KC_DIGIT) begin
                    w_op_x_nxt  = W'(w_dec.digit);
                    w_x_cnt_nxt = CW'(1);
                    w_op_y_nxt  = '0;
                    w_y_cnt_nxt = '0;
                    w_state_nxt = ST_ENTER_X;
                end else if (w_cls == KC_STAR) begin
                    w_op_x_nxt  = '0;
                    w_x_cnt_nxt = '0;
                    w_op_y_nxt  = '0;
                    w_y_cnt_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_ENTER_X;
                end else if (w_cls == KC_HASH) begin
                    // Chained result counts as a full operand: no digits append.
                    w_op_x_nxt  = r_result;
                    w_x_cnt_nxt = MAXC;
                    w_state_nxt = ST_WAIT_OP;
                end
            end
            default: w_state_nxt = ST_ENTER_X;
        endcase
    end

    always_comb begin
        disp_val = r_result;
        case (r_state)
            ST_ENTER_X, ST_WAIT_OP:   disp_val = r_op_x;
            ST_WAIT_STAR, ST_ENTER_Y: disp_val = r_op_y;
            default:                  disp_val = r_result;
        endcase
    end

    assign op_x      = r_op_x;
    assign op_y      = r_op_y;
    assign alu_op    = r_alu_op;
    assign alu_start = w_start;
    assign result    = r_result;
    assign state_o   = r_state;
    assign err       = r_err;

endmodule
